// File: rtl/mem_port_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_if
// Bundles the requester-side handshake and the memory-side control bus of
// mem_port_arbiter into one interface.
//   Requester side : req_i, we_i, lock_i, addr_i, wdata_i  (to arbiter)
//                    gnt_o, rvalid_o, rdata_o              (from arbiter)
//   Memory side    : write, w_addr, w_data, read, r_addr   (from arbiter)
//                    r_data                                (to arbiter)
// Packed vectors place requester k at [k*ADDR_W +: ADDR_W] / [k*WORD_W +: WORD_W].
// Modports: slave  = the arbiter itself
//           master = requesters plus memory (the environment around it)
// -----------------------------------------------------------------------------
interface mem_port_arbiter_if #(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 10,
    parameter int WORD_W  = 64
);
    logic [NUM_REQ-1:0]        req_i;
    logic [NUM_REQ-1:0]        we_i;
    logic [NUM_REQ-1:0]        lock_i;
    logic [NUM_REQ*ADDR_W-1:0] addr_i;
    logic [NUM_REQ*WORD_W-1:0] wdata_i;
    logic [NUM_REQ-1:0]        gnt_o;
    logic [NUM_REQ-1:0]        rvalid_o;
    logic [WORD_W-1:0]         rdata_o;
    logic                      write;
    logic [ADDR_W-1:0]         w_addr;
    logic [WORD_W-1:0]         w_data;
    logic                      read;
    logic [ADDR_W-1:0]         r_addr;
    logic [WORD_W-1:0]         r_data;

    modport slave (
        input  req_i, we_i, lock_i, addr_i, wdata_i, r_data,
        output gnt_o, rvalid_o, rdata_o, write, w_addr, w_data, read, r_addr
    );

    modport master (
        output req_i, we_i, lock_i, addr_i, wdata_i, r_data,
        input  gnt_o, rvalid_o, rdata_o, write, w_addr, w_data, read, r_addr
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
// Round-robin arbiter sharing one memory (one read port, one write port, one
// access per cycle) between NUM_REQ requesters. Grants are combinational; the
// memory bus is driven from the winner in the same cycle and read data is
// routed back to that requester one cycle later via a one-hot tag. A requester
// may lock the port for bursts, bounded by MAX_HOLD while others are waiting.
// Ports:
//   clk_i  - clock, rising edge
//   rst_i  - asynchronous active-high reset
//   bus    - mem_port_arbiter_if.slave (requester handshake + memory bus)
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int NUM_REQ  = 2,
    parameter int ADDR_W   = 10,
    parameter int WORD_W   = 64,
    parameter int MAX_HOLD = 4
) (
    input  logic                clk_i,
    input  logic                rst_i,
    mem_port_arbiter_if.slave   bus
);
    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int HW = $clog2(MAX_HOLD + 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);
    localparam logic [PW-1:0] LAST_IDX = PW'(NUM_REQ - 1);

    typedef enum logic {
        S_FREE = 1'b0,
        S_LOCK = 1'b1
    } state_t;

    state_t              r_state, w_state_next;
    logic [PW-1:0]       r_prio, w_prio_next;
    logic [PW-1:0]       r_own, w_own_next;
    logic [HW-1:0]       r_hcnt, w_hcnt_next;
    logic [NUM_REQ-1:0]  r_rtag, w_rtag_next;

    logic [NUM_REQ-1:0]  w_own_oh;
    logic [NUM_REQ-1:0]  w_cand;
    logic [NUM_REQ-1:0]  w_gnt;
    logic [PW-1:0]       w_win;
    logic [PW-1:0]       w_win_inc;
    logic                w_any;
    logic                w_others;
    logic                w_hold_ok;
    logic                w_we;
    logic [ADDR_W-1:0]   w_addr_arr  [NUM_REQ];
    logic [WORD_W-1:0]   w_wdata_arr [NUM_REQ];

    // Unpack per-requester fields, build owner one-hot and the grant vector.
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
            assign w_addr_arr[gi]  = bus.addr_i[gi*ADDR_W +: ADDR_W];
            assign w_wdata_arr[gi] = bus.wdata_i[gi*WORD_W +: WORD_W];
            assign w_own_oh[gi]    = (r_own == PW'(gi));
            assign w_gnt[gi]       = w_any && (w_win == PW'(gi));
        end
    endgenerate

    // Winner selection. In S_LOCK the owner keeps the port while its hold is
    // not exhausted or nobody else is asking; otherwise the owner is masked
    // out and the rest arbitrate round-robin from prio.
    always_comb begin
        int idx;
        idx       = 0;
        w_any     = 1'b0;
        w_win     = '0;
        w_others  = |(bus.req_i & ~w_own_oh);
        w_hold_ok = (r_state == S_LOCK) && bus.req_i[r_own] &&
                    ((r_hcnt < HOLD_MAX) || !w_others);
        if (w_hold_ok)
            w_cand = w_own_oh;
        else if (r_state == S_LOCK)
            w_cand = bus.req_i & ~w_own_oh;
        else
            w_cand = bus.req_i;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = int'(r_prio) + i;
            if (idx >= NUM_REQ)
                idx = idx - NUM_REQ;
            if (!w_any && w_cand[idx[PW-1:0]]) begin
                w_any = 1'b1;
                w_win = idx[PW-1:0];
            end
        end
    end

    assign w_win_inc = (w_win == LAST_IDX) ? '0 : w_win + 1'b1;
    assign w_we      = bus.we_i[w_win];

    // Memory bus: unused address/data lanes are forced to zero.
    assign bus.gnt_o    = w_gnt;
    assign bus.write    = w_any && w_we;
    assign bus.read     = w_any && !w_we;
    assign bus.w_addr   = bus.write ? w_addr_arr[w_win]  : '0;
    assign bus.w_data   = bus.write ? w_wdata_arr[w_win] : '0;
    assign bus.r_addr   = bus.read  ? w_addr_arr[w_win]  : '0;
    assign bus.rvalid_o = r_rtag;
    assign bus.rdata_o  = bus.r_data;

    // Next-state logic.
    always_comb begin
        w_state_next = r_state;
        w_prio_next  = r_prio;
        w_own_next   = r_own;
        w_hcnt_next  = r_hcnt;
        w_rtag_next  = bus.read ? w_gnt : '0;
        if (w_any)
            w_prio_next = w_win_inc;
        case (r_state)
            S_FREE: begin
                if (w_any && bus.lock_i[w_win]) begin
                    w_own_next   = w_win;
                    w_hcnt_next  = HW'(1);
                    w_state_next = S_LOCK;
                end
            end
            S_LOCK: begin
                if (w_hold_ok) begin
                    if (r_hcnt != HOLD_MAX)
                        w_hcnt_next = r_hcnt + 1'b1;
                    if (!bus.lock_i[r_own])
                        w_state_next = S_FREE;
                end else if (w_any && bus.lock_i[w_win]) begin
                    // A non-owner won and immediately takes over the lock.
                    w_own_next   = w_win;
                    w_hcnt_next  = HW'(1);
                    w_state_next = S_LOCK;
                end else begin
                    w_state_next = S_FREE;
                end
            end
            default: w_state_next = S_FREE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_FREE;
            r_prio  <= '0;
            r_own   <= '0;
            r_hcnt  <= '0;
            r_rtag  <= '0;
        end else begin
            r_state <= w_state_next;
            r_prio  <= w_prio_next;
            r_own   <= w_own_next;
            r_hcnt  <= w_hcnt_next;
            r_rtag  <= w_rtag_next;
        end
    end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Round-robin arbiter that shares the single calculator memory (one read port, one write port, one access per cycle) between NUM_REQ requesters, e.g. several calculator controllers or a controller plus a host loader. Each cycle it grants at most one request, drives the memory control bus from the winner, and routes read data back to that requester one cycle later. Optional locking lets a requester keep the port for short bursts, bounded by MAX_HOLD.

## Interface
- NUM_REQ, 2: number of requesters (2..8)
- ADDR_W, 10: memory address width
- WORD_W, 64: memory word width
- MAX_HOLD, 4: max consecutive grants to one locked requester while another is requesting (≥1)
- clk_i  in  1  clock, rising edge
- rst_i  in  1  reset; one clock, asynchronous, active-high
- req_i  in  NUM_REQ  per-requester access request
- we_i  in  NUM_REQ  1 = write, 0 = read
- lock_i  in  NUM_REQ  requester wants to keep the port after this grant
- addr_i  in  NUM_REQ*ADDR_W  packed addresses, requester k at [k*ADDR_W +: ADDR_W]
- wdata_i  in  NUM_REQ*WORD_W  packed write data, same packing
- gnt_o  out  NUM_REQ  one-hot or zero; access accepted this cycle
- rvalid_o  out  NUM_REQ  one-hot or zero; rdata_o belongs to this requester
- rdata_o  out  WORD_W  read data, shared by all requesters
- write  out  1  memory write enable
- w_addr  out  ADDR_W  memory write address
- w_data  out  WORD_W  memory write data
- read  out  1  memory read enable
- r_addr  out  ADDR_W  memory read address
- r_data  in  WORD_W  memory read data, valid one cycle after read

## Operation
- Registers: priority pointer `prio` (index), owner `own` (index), hold counter `hcnt` (0..MAX_HOLD), state, and read-return tag `rtag` (one-hot NUM_REQ).
- States:
  - S_FREE: no owner. Winner = first requesting index scanning prio, prio+1, …, wrapping modulo NUM_REQ.
    - On grant: prio <= winner+1 (wrapping).
    - If lock_i[winner]: own <= winner, hcnt <= 1, go to S_LOCK.
  - S_LOCK: owner has priority.
    - If req_i[own] and (hcnt < MAX_HOLD or no other req_i): grant own. hcnt saturates at MAX_HOLD.
    - Otherwise, or when owner does not request: arbitrate as in S_FREE, excluding own if its hold expired.
    - Leave to S_FREE when a grant goes to the owner with lock_i low, when the owner drops req_i, or when a non-owner is granted. In that last case the non-owner may itself start a new lock: own <= winner, hcnt <= 1.
- Memory bus, driven combinationally from the winner g:
  - Write grant: write=1, w_addr=addr[g], w_data=wdata[g].
  - Read grant: read=1, r_addr=addr[g].
  - Unused address/data outputs are 0. read and write are never both 1.
- Read return:
  - rtag <= onehot(g) on a read grant, else 0.
  - rvalid_o = rtag, rdata_o = r_data (pass-through, unregistered).
- gnt_o is 0 for every requester with req_i low. Requests are single-cycle transactions: a requester that is not granted holds req_i, we_i and addr_i stable until granted.
- Simultaneous requests: exactly one grant per cycle. No request is starved longer than (NUM_REQ-1)*MAX_HOLD cycles.

## Timing
- Grant is combinational, same cycle as req_i. The memory access occurs on that clock edge.
- Read latency: rvalid_o and rdata_o are valid exactly 1 cycle after the grant. Back-to-back reads from different requesters give back-to-back rvalid_o with the correct one-hot.
- Write: complete at the grant edge. No response.
- Reset (asynchronous, takes effect immediately):
  - state=S_FREE, prio=0, own=0, hcnt=0, rtag=0.
  - Hence rvalid_o=0, and gnt_o/write/read are 0 unless req_i is high.
  - Reset during a read drops that read's rvalid.
- Counters: prio and own wrap modulo NUM_REQ. hcnt saturates and never wraps.

## Test plan
- Single requester: req_i=01, we=0, addr0=0x005 → gnt_o=01, read=1, r_addr=0x005 the same cycle. Next cycle rvalid_o=01, rdata_o=mem[0x005].
- Contention, no lock: req_i=11 held for 4 cycles, both reads → grants 01,10,01,10. rvalid_o follows one cycle later with the same sequence. read=1 every cycle.
- Lock with MAX_HOLD=4: req0 continuous with lock=1, req1 continuous → grants to 0 for 4 cycles, then 1, then 0 again. Req1 waits ≤4 cycles.
- Lock, no contention: req0 lock=1 for 6 cycles, req1 idle → 6 consecutive grants to 0. Req1 raised on cycle 7 is granted within MAX_HOLD cycles.
- Write/read ordering: req0 writes 0xDEAD at 0x010 while req1 reads 0x010 in the same cycle, prio=0 → write granted first. Req1's read next cycle returns 0xDEAD.
- Asynchronous reset asserted mid-cycle right after a read grant → rvalid_o falls to 0 immediately with no clock edge. After release, prio=0 and req_i=11 grants requester 0 first.
